// File: rtl/intra_layer_sched_pkg.sv
// Shared state encoding and block-type codes for the intra-layer block scheduler.
package intra_layer_sched_pkg;

    typedef enum logic [1:0] {
        S_F    = 2'd0,
        S_FB   = 2'd1,
        S_B    = 2'd2,
        S_DONE = 2'd3
    } sched_state_e;

    localparam logic [1:0] TYPE_FWD  = 2'b01;
    localparam logic [1:0] TYPE_MIX  = 2'b11;
    localparam logic [1:0] TYPE_BWD  = 2'b10;
    localparam logic [1:0] TYPE_IDLE = 2'b00;

    function automatic sched_state_e next_step(input sched_state_e cur);
        sched_state_e nxt;
        case (cur)
            S_F:     nxt = S_FB;
            S_FB:    nxt = S_B;
            S_B:     nxt = S_DONE;
            default: nxt = S_F;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/intra_layer_block_scheduler_split.sv
// Splits a pass of length L at breakpoint P into a clamped head and the remaining tail.
module block_segment_split
    import intra_layer_sched_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] len_i,
    input  logic [DATA_W-1:0] bp_i,
    output logic [DATA_W-1:0] head_len_o,
    output logic [DATA_W-1:0] tail_start_o,
    output logic [DATA_W-1:0] tail_len_o
);

    logic [DATA_W-1:0] head;

    // Clamping keeps the tail subtraction from ever wrapping.
    assign head         = (bp_i < len_i) ? bp_i : len_i;
    assign head_len_o   = head;
    assign tail_start_o = head;
    assign tail_len_o   = len_i - head;

endmodule

// File: rtl/intra_layer_block_scheduler.sv
// Steps one layer through forward / overlap / backward / done, one step per finish event.
// Optional macro INTRA_LAYER_SCHED_LAYER_CNT_EN adds a 16-bit completed-layer counter.
//
// state  | meaning
// S_F    | forward head only on block0
// S_FB   | forward tail on block0 overlapped with backward head on block1
// S_B    | backward tail only on block1
// S_DONE | layer finished, both lanes idle
module intra_layer_block_scheduler
    import intra_layer_sched_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              block_finish_valid_i,
    input  logic [DATA_W-1:0] forward_length_i,
    input  logic [DATA_W-1:0] backward_length_i,
    input  logic [DATA_W-1:0] forward_breakpoint_i,
    input  logic [DATA_W-1:0] backward_breakpoint_i,
    output logic [DATA_W-1:0] block0_start_o,
    output logic [DATA_W-1:0] block0_length_o,
    output logic [DATA_W-1:0] block1_start_o,
    output logic [DATA_W-1:0] block1_length_o,
`ifdef INTRA_LAYER_SCHED_LAYER_CNT_EN
    output logic [15:0]       layer_count_o,
`endif
    output logic [1:0]        block_type_o
);

    sched_state_e      state_q, state_d;
    logic              finish_q, finish_d;
    logic              evt;
    logic              load_cfg;
    logic [DATA_W-1:0] c_f_q, c_f_d;
    logic [DATA_W-1:0] c_b_q, c_b_d;
    logic [DATA_W-1:0] c_fb_q, c_fb_d;
    logic [DATA_W-1:0] c_bb_q, c_bb_d;

    logic [DATA_W-1:0] fwd_head, fwd_tail_start, fwd_tail_len;
    logic [DATA_W-1:0] bwd_head, bwd_tail_start, bwd_tail_len;

    assign evt = block_finish_valid_i & ~finish_q;

    always_comb begin
        load_cfg = rst_i | ((state_q == S_DONE) & evt);
        c_f_d    = load_cfg ? forward_length_i      : c_f_q;
        c_b_d    = load_cfg ? backward_length_i     : c_b_q;
        c_fb_d   = load_cfg ? forward_breakpoint_i  : c_fb_q;
        c_bb_d   = load_cfg ? backward_breakpoint_i : c_bb_q;
        state_d  = evt ? next_step(state_q) : state_q;
        finish_d = block_finish_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_F;
        end else begin
            state_q <= state_d;
        end
    end

    // finish_q tracks valid even in reset (0 whenever valid is idle), so a valid
    // still held high across reset release is not mistaken for a fresh edge.
    always_ff @(posedge clk_i) begin
        finish_q <= finish_d;
    end

    always_ff @(posedge clk_i) begin
        c_f_q  <= c_f_d;
        c_b_q  <= c_b_d;
        c_fb_q <= c_fb_d;
        c_bb_q <= c_bb_d;
    end

    block_segment_split #(.DATA_W(DATA_W)) u_fwd_split (
        .len_i        (c_f_q),
        .bp_i         (c_fb_q),
        .head_len_o   (fwd_head),
        .tail_start_o (fwd_tail_start),
        .tail_len_o   (fwd_tail_len)
    );

    block_segment_split #(.DATA_W(DATA_W)) u_bwd_split (
        .len_i        (c_b_q),
        .bp_i         (c_bb_q),
        .head_len_o   (bwd_head),
        .tail_start_o (bwd_tail_start),
        .tail_len_o   (bwd_tail_len)
    );

    always_comb begin
        block_type_o    = TYPE_IDLE;
        block0_start_o  = '0;
        block0_length_o = '0;
        block1_start_o  = '0;
        block1_length_o = '0;
        case (state_q)
            S_F: begin
                block_type_o    = TYPE_FWD;
                block0_length_o = fwd_head;
            end
            S_FB: begin
                block_type_o    = TYPE_MIX;
                block0_start_o  = fwd_tail_start;
                block0_length_o = fwd_tail_len;
                block1_length_o = bwd_head;
            end
            S_B: begin
                block_type_o    = TYPE_BWD;
                block1_start_o  = bwd_tail_start;
                block1_length_o = bwd_tail_len;
            end
            default: begin
                block_type_o = TYPE_IDLE;
            end
        endcase
    end

`ifdef INTRA_LAYER_SCHED_LAYER_CNT_EN
    logic [15:0] layer_cnt_q, layer_cnt_d;

    always_comb begin
        layer_cnt_d = layer_cnt_q;
        if ((state_q == S_B) && evt) begin
            layer_cnt_d = layer_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            layer_cnt_q <= '0;
        end else begin
            layer_cnt_q <= layer_cnt_d;
        end
    end

    assign layer_count_o = layer_cnt_q;
`endif

endmodule

// File: tb/tb_intra_layer_block_scheduler.sv
// Scoreboard bench: driver pushes expected outputs per cycle, monitor pops and compares.
module tb_intra_layer_block_scheduler;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [DW-1:0] f_in, b_in, fb_in, bb_in;
    logic [DW-1:0] b0s, b0l, b1s, b1l;
    logic [1:0]    btype;
    logic [15:0]   lcnt;

    intra_layer_block_scheduler #(.DATA_W(DW)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .block_finish_valid_i  (valid),
        .forward_length_i      (f_in),
        .backward_length_i     (b_in),
        .forward_breakpoint_i  (fb_in),
        .backward_breakpoint_i (bb_in),
        .block0_start_o        (b0s),
        .block0_length_o       (b0l),
        .block1_start_o        (b1s),
        .block1_length_o       (b1l),
`ifdef INTRA_LAYER_SCHED_LAYER_CNT_EN
        .layer_count_o         (lcnt),
`endif
        .block_type_o          (btype)
    );

`ifndef INTRA_LAYER_SCHED_LAYER_CNT_EN
    assign lcnt = 16'd0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    typ;
        logic [DW-1:0] s0, l0, s1, l1;
        logic [15:0]   cnt;
        int            due;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference: layer phase index 0..3 plus the configuration snapshot for the layer.
    int            phase;
    logic [DW-1:0] m_f, m_b, m_fb, m_bb;
    logic [15:0]   m_cnt;

    function automatic logic [DW-1:0] umin(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic exp_t model_out(input int due);
        exp_t e;
        logic [DW-1:0] fh, bh;
        fh = umin(m_fb, m_f);
        bh = umin(m_bb, m_b);
        e.typ = 2'b00; e.s0 = '0; e.l0 = '0; e.s1 = '0; e.l1 = '0;
        e.cnt = m_cnt;
        e.due = due;
        if (phase == 0) begin
            e.typ = 2'b01; e.l0 = fh;
        end else if (phase == 1) begin
            e.typ = 2'b11; e.s0 = fh; e.l0 = m_f - fh; e.l1 = bh;
        end else if (phase == 2) begin
            e.typ = 2'b10; e.s1 = bh; e.l1 = m_b - bh;
        end
        return e;
    endfunction

    task automatic capture_cfg();
        m_f = f_in; m_b = b_in; m_fb = fb_in; m_bb = bb_in;
    endtask

    task automatic expect_next();
        exp_q.push_back(model_out(cyc + 1));
    endtask

    task automatic advance_model();
        if (phase == 3) begin
            phase = 0;
            capture_cfg();
        end else begin
`ifdef INTRA_LAYER_SCHED_LAYER_CNT_EN
            if (phase == 2) m_cnt = m_cnt + 16'd1;
`endif
            phase = phase + 1;
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic idle(input int n);
        repeat (n) begin
            expect_next();
            @(negedge clk);
        end
    endtask

    task automatic pulse(input int w);
        valid = 1'b1;
        advance_model();
        expect_next();
        @(negedge clk);
        repeat (w - 1) begin
            expect_next();
            @(negedge clk);
        end
        valid = 1'b0;
        expect_next();
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        phase = 0;
        m_cnt = '0;
        capture_cfg();
        repeat (n) begin
            expect_next();
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic set_cfg(input logic [DW-1:0] f, input logic [DW-1:0] b,
                           input logic [DW-1:0] fb, input logic [DW-1:0] bb);
        f_in = f; b_in = b; fb_in = fb; bb_in = bb;
    endtask

    function automatic logic [DW-1:0] rand_val();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return '1;
        if (sel == 1) return $urandom;
        return DW'($urandom_range(0, 20));
    endfunction

    task automatic direct_check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: compares every output field whenever a scheduled expectation falls due.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (e.due != cyc || btype !== e.typ || b0s !== e.s0 || b0l !== e.l0 ||
                    b1s !== e.s1 || b1l !== e.l1 || lcnt !== e.cnt) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d due=%0d actual type=%b b0=(%0d,%0d) b1=(%0d,%0d) cnt=%0d required type=%b b0=(%0d,%0d) b1=(%0d,%0d) cnt=%0d",
                             cyc, e.due, btype, b0s, b0l, b1s, b1l, lcnt,
                             e.typ, e.s0, e.l0, e.s1, e.l1, e.cnt);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        valid = 1'b0;
        set_cfg(32'd10, 32'd4, 32'd7, 32'd3);
        @(negedge clk);
        do_reset(2);
        direct_check("reset_type", DW'(btype), 32'd1);
        direct_check("reset_b0_len", b0l, 32'd7);
        idle(2);

        // Directed walk through one layer with stretched valid pulses.
        pulse(1);
        idle(1);
        pulse(2);
        idle(2);
        pulse(3);
        idle(1);
        direct_check("done_type", DW'(btype), 32'd0);
        pulse(1);
        direct_check("relayer_b0_len", b0l, 32'd7);
        idle(1);

        // Breakpoints beyond the pass lengths clamp to the full length.
        pulse(1); pulse(1); pulse(1);
        set_cfg(32'd10, 32'd4, 32'd12, 32'd9);
        idle(1);
        pulse(1);
        direct_check("clamp_b0_len", b0l, 32'd10);
        pulse(1);
        direct_check("clamp_tail_len", b0l, 32'd0);
        set_cfg(32'd99, 32'd55, 32'd3, 32'd1);
        idle(3);
        pulse(2);
        direct_check("clamp_b1_start", b1s, 32'd4);

        // Reset in S_B with valid held high across release.
        rst = 1'b1;
        valid = 1'b1;
        set_cfg(32'd10, 32'd4, 32'd7, 32'd3);
        do_reset(2);
        idle(4);
        direct_check("post_reset_hold_type", DW'(btype), 32'd1);
        valid = 1'b0;
        idle(2);
        pulse(1);
        idle(1);

        // Randomized traffic with config changes both mid-layer and between layers.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                set_cfg(rand_val(), rand_val(), rand_val(), rand_val());
            end
            idle($urandom_range(0, 3));
            pulse($urandom_range(1, 4));
            if ($urandom_range(0, 60) == 0) begin
                if ($urandom_range(0, 1) == 1) valid = 1'b1;
                do_reset($urandom_range(1, 3));
                idle($urandom_range(1, 3));
                valid = 1'b0;
                idle(1);
            end
        end

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
